// File: rtl/pirad_spi_axil_regs.sv
// pirad_spi_axil_regs
// AXI4-Lite responder holding the four 32-bit PiRadSPI control/data registers.
// Write address and write data land in independent one-entry slots; once both
// are full and no write response is outstanding the pair commits, raising
// bvalid and a one-cycle wr_pulse_o bit for the target register. Reads are
// answered from the register file one edge after the AR handshake.
//
// Optional feature: define PIRAD_SPI_AXIL_WSTRB_EN to honour s_axi_wstrb byte
// lanes. Without it the full word is always written and wstrb is ignored.
module pirad_spi_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [3:0]                      wr_pulse_o
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int LANES = C_S_AXI_DATA_WIDTH / 8;

`ifdef PIRAD_SPI_AXIL_WSTRB_EN
    // Replace only the byte lanes whose strobe is set.
    function automatic logic [DW-1:0] merge_strb(
        input logic [DW-1:0]    old_v,
        input logic [DW-1:0]    new_v,
        input logic [LANES-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_v;
        for (int k = 0; k < LANES; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_v[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_v[8*k +: 8];
            end
        end
        return res;
    endfunction
`endif

    // State registers and their next-state values
    logic             aw_full_q,  aw_full_d;
    logic [1:0]       aw_idx_q,   aw_idx_d;
    logic             w_full_q,   w_full_d;
    logic [DW-1:0]    w_data_q,   w_data_d;
`ifdef PIRAD_SPI_AXIL_WSTRB_EN
    logic [LANES-1:0] w_strb_q,   w_strb_d;
`endif
    logic             bvalid_q,   bvalid_d;
    logic             rvalid_q,   rvalid_d;
    logic [DW-1:0]    rdata_q,    rdata_d;
    logic [3:0]       wr_pulse_q, wr_pulse_d;
    logic [DW-1:0]    regs_q [4];
    logic [DW-1:0]    regs_d [4];

    logic             aw_hs_s;
    logic             w_hs_s;
    logic             ar_hs_s;
    logic             commit_s;
    logic [DW-1:0]    wr_value_s;

    // Ports the register map does not decode are folded here so they are
    // visibly consumed; the byte-offset address bits and prot carry no meaning.
    logic             unused_s;
`ifdef PIRAD_SPI_AXIL_WSTRB_EN
    assign unused_s = ^{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};
`else
    assign unused_s = ^{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr,
                        s_axi_wstrb};
`endif

    // Readies are gated by reset so nothing is accepted while it is asserted.
    assign s_axi_awready = !aw_full_q && !reset;
    assign s_axi_wready  = !w_full_q && !reset;
    assign s_axi_arready = !rvalid_q && !reset;

    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign wr_pulse_o    = wr_pulse_q;
    assign regs_o        = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

    assign aw_hs_s  = s_axi_awvalid && s_axi_awready;
    assign w_hs_s   = s_axi_wvalid && s_axi_wready;
    assign ar_hs_s  = s_axi_arvalid && s_axi_arready;
    // A full pair waits while the previous response is still outstanding.
    assign commit_s = aw_full_q && w_full_q && !bvalid_q;

`ifdef PIRAD_SPI_AXIL_WSTRB_EN
    assign wr_value_s = merge_strb(regs_q[aw_idx_q], w_data_q, w_strb_q);
`else
    assign wr_value_s = w_data_q;
`endif

    // Next-state logic for slots, responses, read data and the register file.
    always_comb begin
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
`ifdef PIRAD_SPI_AXIL_WSTRB_EN
        w_strb_d   = w_strb_q;
`endif
        bvalid_d   = bvalid_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        wr_pulse_d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end

        // Address slot: handshake only possible while empty, so no overlap
        // with the commit that empties it.
        if (commit_s) begin
            aw_full_d = 1'b0;
        end else if (aw_hs_s) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi_awaddr[3:2];
        end else begin
            aw_full_d = aw_full_q;
        end

        // Data slot, same rules as the address slot.
        if (commit_s) begin
            w_full_d = 1'b0;
        end else if (w_hs_s) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
`ifdef PIRAD_SPI_AXIL_WSTRB_EN
            w_strb_d = s_axi_wstrb;
`endif
        end else begin
            w_full_d = w_full_q;
        end

        // Commit updates the target register and raises the response.
        if (commit_s) begin
            regs_d[aw_idx_q]     = wr_value_s;
            wr_pulse_d[aw_idx_q] = 1'b1;
            bvalid_d             = 1'b1;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        // Read samples the pre-commit register value, so a same-edge write
        // to the same register is not visible to this read.
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[s_axi_araddr[3:2]];
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // State update with synchronous reset clearing every pending transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            aw_full_q  <= 1'b0;
            aw_idx_q   <= 2'b00;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
`ifdef PIRAD_SPI_AXIL_WSTRB_EN
            w_strb_q   <= '0;
`endif
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            wr_pulse_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
`ifdef PIRAD_SPI_AXIL_WSTRB_EN
            w_strb_q   <= w_strb_d;
`endif
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pirad_spi_axil_regs.sv
// Directed self-checking bench for pirad_spi_axil_regs. Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on the rising one.
module tb_pirad_spi_axil_regs;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   s_axi_awaddr;
    logic [2:0]   s_axi_awprot;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata;
    logic [3:0]   s_axi_wstrb;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [3:0]   s_axi_araddr;
    logic [2:0]   s_axi_arprot;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready;
    logic [127:0] regs_o;
    logic [3:0]   wr_pulse_o;

    int checks = 0;
    int errors = 0;

    pirad_spi_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_field(input logic [127:0] r, input logic [1:0] idx);
        return r[32*idx +: 32];
    endfunction

    // Simultaneous AW+W with bready high; checks latency, pulse and register.
    task automatic write_simple(input logic [3:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [31:0] exp_reg);
        logic [3:0] exp_pulse;
        exp_pulse = 4'b0001 << addr[3:2];
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        check("wr_awready_pre", 128'(s_axi_awready), 128'(1'b1));
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("wr_bvalid_e0", 128'(s_axi_bvalid), 128'(1'b0));
        check("wr_awready_full", 128'(s_axi_awready), 128'(1'b0));
        tick();
        check("wr_bvalid_e1", 128'(s_axi_bvalid), 128'(1'b1));
        check("wr_bresp", 128'(s_axi_bresp), 128'(2'b00));
        check("wr_pulse_e1", 128'(wr_pulse_o), 128'(exp_pulse));
        check("wr_reg", 128'(reg_field(regs_o, addr[3:2])), 128'(exp_reg));
        tick();
        check("wr_bvalid_e2", 128'(s_axi_bvalid), 128'(1'b0));
        check("wr_pulse_e2", 128'(wr_pulse_o), 128'(4'b0000));
    endtask

    // AR with rready high; checks one-edge latency and data.
    task automatic read_simple(input logic [3:0] addr, input logic [31:0] exp_data);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b1;
        check("rd_arready_pre", 128'(s_axi_arready), 128'(1'b1));
        tick();
        s_axi_arvalid = 1'b0;
        check("rd_rvalid", 128'(s_axi_rvalid), 128'(1'b1));
        check("rd_rdata", 128'(s_axi_rdata), 128'(exp_data));
        check("rd_rresp", 128'(s_axi_rresp), 128'(2'b00));
        check("rd_arready_busy", 128'(s_axi_arready), 128'(1'b0));
        tick();
        check("rd_rvalid_done", 128'(s_axi_rvalid), 128'(1'b0));
    endtask

    initial begin
        logic [31:0] exp_strb;
        logic [31:0] exp_zero;
        reset = 1'b1;
        s_axi_awaddr = 4'h0; s_axi_awprot = 3'b000; s_axi_awvalid = 1'b0;
        s_axi_wdata = 32'h0; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = 4'h0; s_axi_arprot = 3'b000; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        @(negedge clock);
        tick();

        // Reset state
        check("rst_awready", 128'(s_axi_awready), 128'(1'b0));
        check("rst_wready", 128'(s_axi_wready), 128'(1'b0));
        check("rst_arready", 128'(s_axi_arready), 128'(1'b0));
        check("rst_bvalid", 128'(s_axi_bvalid), 128'(1'b0));
        check("rst_rvalid", 128'(s_axi_rvalid), 128'(1'b0));
        check("rst_regs", regs_o, 128'h0);
        check("rst_pulse", 128'(wr_pulse_o), 128'(4'b0000));
        reset = 1'b0;
        #1;
        check("post_rst_awready", 128'(s_axi_awready), 128'(1'b1));
        check("post_rst_wready", 128'(s_axi_wready), 128'(1'b1));
        check("post_rst_arready", 128'(s_axi_arready), 128'(1'b1));

        // Sequential write / read-back
        write_simple(4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001);
        write_simple(4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002);
        write_simple(4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003);
        write_simple(4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004);
        check("seq_regs", regs_o, 128'h00000004_00000003_00000002_00000001);
        read_simple(4'h0, 32'h0000_0001);
        read_simple(4'h4, 32'h0000_0002);
        read_simple(4'h8, 32'h0000_0003);
        read_simple(4'hC, 32'h0000_0004);

        // W three cycles ahead of AW
        s_axi_bready = 1'b1;
        s_axi_wdata = 32'hA5A5_A5A5; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        check("skw_wready_low", 128'(s_axi_wready), 128'(1'b0));
        tick();
        tick();
        check("skw_no_commit", 128'(s_axi_bvalid), 128'(1'b0));
        s_axi_awaddr = 4'h8; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("skw_bvalid_e0", 128'(s_axi_bvalid), 128'(1'b0));
        tick();
        check("skw_bvalid_e1", 128'(s_axi_bvalid), 128'(1'b1));
        check("skw_pulse", 128'(wr_pulse_o), 128'(4'b0100));
        check("skw_reg2", 128'(regs_o[95:64]), 128'(32'hA5A5_A5A5));
        tick();

        // AW three cycles ahead of W
        s_axi_awaddr = 4'hC; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("skw2_awready_low", 128'(s_axi_awready), 128'(1'b0));
        tick();
        tick();
        check("skw2_no_commit", 128'(s_axi_bvalid), 128'(1'b0));
        s_axi_wdata = 32'h5A5A_5A5A; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        tick();
        check("skw2_bvalid", 128'(s_axi_bvalid), 128'(1'b1));
        check("skw2_pulse", 128'(wr_pulse_o), 128'(4'b1000));
        check("skw2_reg3", 128'(regs_o[127:96]), 128'(32'h5A5A_5A5A));
        tick();

        // Write response backpressure with a second pair queued
        s_axi_bready = 1'b0;
        s_axi_awaddr = 4'h0; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0000_0010; s_axi_wvalid = 1'b1;
        tick();
        tick();
        check("bp_first_bvalid", 128'(s_axi_bvalid), 128'(1'b1));
        s_axi_awaddr = 4'h4; s_axi_wdata = 32'h0000_0020;
        check("bp_second_ready", 128'({s_axi_awready, s_axi_wready}), 128'(2'b11));
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_bvalid", 128'(s_axi_bvalid), 128'(1'b1));
            check("bp_hold_readies", 128'({s_axi_awready, s_axi_wready}), 128'(2'b00));
            check("bp_hold_pulse", 128'(wr_pulse_o), 128'(4'b0000));
            check("bp_hold_reg1", 128'(regs_o[63:32]), 128'(32'h0000_0002));
            tick();
        end
        s_axi_bready = 1'b1;
        tick();
        check("bp_b_done", 128'(s_axi_bvalid), 128'(1'b0));
        tick();
        check("bp_second_bvalid", 128'(s_axi_bvalid), 128'(1'b1));
        check("bp_second_pulse", 128'(wr_pulse_o), 128'(4'b0010));
        check("bp_second_reg1", 128'(regs_o[63:32]), 128'(32'h0000_0020));
        tick();

        // Read data backpressure
        s_axi_rready = 1'b0;
        s_axi_araddr = 4'h0; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rbp_rvalid", 128'(s_axi_rvalid), 128'(1'b1));
            check("rbp_rdata", 128'(s_axi_rdata), 128'(32'h0000_0010));
            check("rbp_arready", 128'(s_axi_arready), 128'(1'b0));
            tick();
        end
        s_axi_rready = 1'b1;
        tick();
        check("rbp_done", 128'(s_axi_rvalid), 128'(1'b0));

        // Same-edge write commit and read of reg1
        write_simple(4'h4, 32'h0000_0011, 4'hF, 32'h0000_0011);
        s_axi_awaddr = 4'h4; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0000_0022; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        s_axi_araddr = 4'h4; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check("col_bvalid", 128'(s_axi_bvalid), 128'(1'b1));
        check("col_rvalid", 128'(s_axi_rvalid), 128'(1'b1));
        check("col_rdata_old", 128'(s_axi_rdata), 128'(32'h0000_0011));
        tick();
        read_simple(4'h4, 32'h0000_0022);

        // Byte strobes
`ifdef PIRAD_SPI_AXIL_WSTRB_EN
        exp_strb = 32'hFF34_FF78;
        exp_zero = 32'hFF34_FF78;
`else
        exp_strb = 32'h1234_5678;
        exp_zero = 32'h0000_DEAD;
`endif
        write_simple(4'h8, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF);
        write_simple(4'h8, 32'h1234_5678, 4'b0101, exp_strb);
        write_simple(4'h8, 32'h0000_DEAD, 4'b0000, exp_zero);

        // Reset while both responses are pending
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        s_axi_awaddr = 4'h0; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0000_0077; s_axi_wvalid = 1'b1;
        s_axi_araddr = 4'hC; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        tick();
        check("mid_bvalid", 128'(s_axi_bvalid), 128'(1'b1));
        check("mid_rvalid", 128'(s_axi_rvalid), 128'(1'b1));
        reset = 1'b1;
        #1;
        check("mid_readies_in_rst", 128'({s_axi_awready, s_axi_wready, s_axi_arready}), 128'(3'b000));
        tick();
        check("mid_bvalid_rst", 128'(s_axi_bvalid), 128'(1'b0));
        check("mid_rvalid_rst", 128'(s_axi_rvalid), 128'(1'b0));
        check("mid_rdata_rst", 128'(s_axi_rdata), 128'(32'h0));
        check("mid_regs_rst", regs_o, 128'h0);
        check("mid_pulse_rst", 128'(wr_pulse_o), 128'(4'b0000));
        check("mid_readies_rst", 128'({s_axi_awready, s_axi_wready, s_axi_arready}), 128'(3'b000));
        reset = 1'b0;
        #1;
        check("mid_readies_after", 128'({s_axi_awready, s_axi_wready, s_axi_arready}), 128'(3'b111));
        tick();
        check("mid_no_commit", 128'(s_axi_bvalid), 128'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
